psk_symbol_detector: RTL and testbench

- Receive-side counterpart of the 16-point LUT carrier generators (16 samples per carrier period, 8-bit unsigned samples centred at 100).
- Consumes one symbol of 16 samples and correlates it against internal sine and cosine tables to recover the in-phase and quadrature amplitudes.
- Slices the result to one of 8 phase sectors (k·π/4) and flags low-energy symbols as erasures.
- Sits between the sample source (generator or ADC path) and the symbol sink.

---
 rtl/psk_detect_pkg.sv | 31 +++
 rtl/psk_sector_slicer.sv | 56 +++++
 rtl/psk_symbol_detector.sv | 180 ++++++++++++++++++
 tb/tb_psk_symbol_detector.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psk_detect_pkg.sv
// Shared definitions for the PSK symbol detector.
//   SAMPLES_PER_SYM : samples per carrier period / symbol
//   ACC_W_DEFAULT   : default signed accumulator and output width
//   SIN_LUT/COS_LUT : 16-point correlation tables, amplitude 64
//   sector_e        : eight phase sectors, PH_0 on +I, counter-clockwise
//   state_e         : symbol FSM states
package psk_detect_pkg;

    localparam int SAMPLES_PER_SYM = 16;
    localparam int ACC_W_DEFAULT   = 20;

    localparam logic signed [7:0] SIN_LUT [SAMPLES_PER_SYM] = '{
        8'sd0,   8'sd24,  8'sd45,  8'sd59,  8'sd64,  8'sd59,  8'sd45,  8'sd24,
        8'sd0,  -8'sd24, -8'sd45, -8'sd59, -8'sd64, -8'sd59, -8'sd45, -8'sd24
    };

    // Quarter-period rotation of SIN_LUT.
    localparam logic signed [7:0] COS_LUT [SAMPLES_PER_SYM] = '{
        8'sd64,  8'sd59,  8'sd45,  8'sd24,  8'sd0,  -8'sd24, -8'sd45, -8'sd59,
       -8'sd64, -8'sd59, -8'sd45, -8'sd24,  8'sd0,   8'sd24,  8'sd45,  8'sd59
    };

    typedef enum logic [2:0] {
        PH_0, PH_1, PH_2, PH_3, PH_4, PH_5, PH_6, PH_7
    } sector_e;

    typedef enum logic [1:0] {
        IDLE, ACCUM, DONE
    } state_e;

endpackage

// File: rtl/psk_sector_slicer.sv
// Combinational phase slicer for one correlated symbol.
//   i, q    : signed in-phase / quadrature correlation sums
//   phase   : nearest of eight k*pi/4 sectors (PH_0 = +I axis, CCW)
//   erasure : |I|+|Q| below MIN_MAG
module psk_sector_slicer
    import psk_detect_pkg::*;
#(
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int MIN_MAG = 4096
) (
    input  logic signed [ACC_W-1:0] i,
    input  logic signed [ACC_W-1:0] q,
    output sector_e                 phase,
    output logic                    erasure
);

    // One extra bit so the most negative input still has a representable magnitude.
    function automatic logic [ACC_W:0] abs_mag(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] w;
        w = (ACC_W+1)'(v);
        return w[ACC_W] ? $unsigned(-w) : $unsigned(w);
    endfunction

    logic [ACC_W:0]   mag_i, mag_q, major, minor;
    logic [ACC_W+3:0] minor5, major2;
    logic [ACC_W+1:0] mag_sum;
    logic             i_major, on_axis;

    always_comb begin
        mag_i   = abs_mag(i);
        mag_q   = abs_mag(q);
        i_major = (mag_i >= mag_q);
        major   = i_major ? mag_i : mag_q;
        minor   = i_major ? mag_q : mag_i;
        // minor/major < 2/5 approximates tan(22.5 deg); equality falls to the diagonal.
        minor5  = ((ACC_W+4)'(minor) << 2) + (ACC_W+4)'(minor);
        major2  = (ACC_W+4)'(major) << 1;
        on_axis = (minor5 < major2);
        mag_sum = (ACC_W+2)'(mag_i) + (ACC_W+2)'(mag_q);
        erasure = (mag_sum < (ACC_W+2)'(MIN_MAG));

        phase = PH_0;
        if (on_axis) begin
            if (i_major) phase = i[ACC_W-1] ? PH_4 : PH_0;
            else         phase = q[ACC_W-1] ? PH_6 : PH_2;
        end else begin
            case ({i[ACC_W-1], q[ACC_W-1]})
                2'b00:   phase = PH_1;
                2'b10:   phase = PH_3;
                2'b11:   phase = PH_5;
                default: phase = PH_7;
            endcase
        end
    end

endmodule

// File: rtl/psk_symbol_detector.sv
// 8-PSK symbol detector: correlates 16-sample symbols (8-bit unsigned,
// DC-centred) against sine/cosine tables and slices the result to a sector.
//   clk, rst_n         : rising-edge clock, async active-low reset
//   in_valid/in_sof    : sample qualifier / first sample of a symbol
//   in_sample          : unsigned sample
//   out_ready          : sink accepts the held result
//   out_valid          : result held until out_ready at an edge
//   out_phase          : sector 0..7
//   out_i, out_q       : signed correlation sums
//   out_erasure        : low-energy symbol
//   err_sof            : one-cycle pulse on a sof inside a symbol
//   overrun            : sticky, a result completed while the old one was held
// Build option PSK_DC_TRACK_EN: DC level follows the mean of the previous
// completed symbol instead of the fixed OFFSET.
module psk_symbol_detector
    import psk_detect_pkg::*;
#(
    parameter int OFFSET  = 100,
    parameter int ACC_W   = ACC_W_DEFAULT,
    parameter int MIN_MAG = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [7:0]              in_sample,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [2:0]              out_phase,
    output logic signed [ACC_W-1:0] out_i,
    output logic signed [ACC_W-1:0] out_q,
    output logic                    out_erasure,
    output logic                    err_sof,
    output logic                    overrun
);

    state_e                  state, state_nxt;
    logic [3:0]              idx;
    logic signed [ACC_W-1:0] acc_i, acc_q;
    logic                    start_sym, step_sym, in_accum, in_done;
    logic [7:0]              dc_level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_sym) state_nxt = ACCUM;
            ACCUM:   if (step_sym && idx == 4'd15) state_nxt = DONE;
            DONE:    state_nxt = start_sym ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A sof sample always (re)starts a symbol, whatever the state.
    always_comb begin
        in_accum  = (state == ACCUM);
        in_done   = (state == DONE);
        start_sym = in_valid && in_sof;
        step_sym  = in_valid && !in_sof && in_accum;
    end

`ifdef PSK_DC_TRACK_EN
    logic [11:0] sample_sum;
    logic [7:0]  dc_est;

    // While in DONE the new estimate is not registered yet; bypass it so a
    // back-to-back sof sample already sees the fresh mean.
    assign dc_level = in_done ? sample_sum[11:4] : dc_est;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_sum <= '0;
            dc_est     <= 8'(OFFSET);
        end else begin
            if (in_done)
                dc_est <= sample_sum[11:4];
            if (start_sym)
                sample_sum <= {4'd0, in_sample};
            else if (step_sym)
                sample_sum <= sample_sum + {4'd0, in_sample};
        end
    end
`else
    assign dc_level = 8'(OFFSET);
`endif

    // ---- p0: centre sample and multiply by table coefficients ----
    logic [3:0]         lut_idx;
    logic signed [8:0]  c_p0;
    logic signed [15:0] prod_i_p0, prod_q_p0;

    always_comb begin
        lut_idx   = start_sym ? 4'd0 : idx;
        c_p0      = $signed({1'b0, in_sample} - {1'b0, dc_level});
        prod_i_p0 = 16'(c_p0) * 16'(SIN_LUT[lut_idx]);
        prod_q_p0 = 16'(c_p0) * 16'(COS_LUT[lut_idx]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            acc_i <= '0;
            acc_q <= '0;
        end else if (start_sym) begin
            idx   <= 4'd1;
            acc_i <= ACC_W'(prod_i_p0);
            acc_q <= ACC_W'(prod_q_p0);
        end else if (step_sym) begin
            idx   <= idx + 4'd1;
            acc_i <= acc_i + ACC_W'(prod_i_p0);
            acc_q <= acc_q + ACC_W'(prod_q_p0);
        end
    end

    // ---- p1: slice final sums during DONE ----
    sector_e                 slice_phase, res_phase_p1;
    logic                    slice_erasure, res_erasure_p1, vld_p1;
    logic signed [ACC_W-1:0] res_i_p1, res_q_p1;

    psk_sector_slicer #(
        .ACC_W   (ACC_W),
        .MIN_MAG (MIN_MAG)
    ) u_slicer (
        .i       (acc_i),
        .q       (acc_q),
        .phase   (slice_phase),
        .erasure (slice_erasure)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1         <= 1'b0;
            res_i_p1       <= '0;
            res_q_p1       <= '0;
            res_phase_p1   <= PH_0;
            res_erasure_p1 <= 1'b0;
        end else begin
            vld_p1 <= in_done;
            if (in_done) begin
                res_i_p1       <= acc_i;
                res_q_p1       <= acc_q;
                res_phase_p1   <= slice_phase;
                res_erasure_p1 <= slice_erasure;
            end
        end
    end

    // ---- p2: output hold register with ready/valid handshake ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_phase   <= '0;
            out_i       <= '0;
            out_q       <= '0;
            out_erasure <= 1'b0;
            overrun     <= 1'b0;
            err_sof     <= 1'b0;
        end else begin
            err_sof <= in_accum && start_sym;
            if (vld_p1) begin
                if (!out_valid || out_ready) begin
                    out_valid   <= 1'b1;
                    out_phase   <= res_phase_p1;
                    out_i       <= res_i_p1;
                    out_q       <= res_q_p1;
                    out_erasure <= res_erasure_p1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_psk_symbol_detector.sv
module tb_psk_symbol_detector;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_sof;
    logic [7:0]         in_sample;
    logic               out_ready;
    logic               out_valid;
    logic [2:0]         out_phase;
    logic signed [19:0] out_i;
    logic signed [19:0] out_q;
    logic               out_erasure;
    logic               err_sof;
    logic               overrun;

    int tests = 0;
    int fails = 0;
    int err_cnt = 0;
    int res_cnt = 0;
    int model_dc = 100;
    int SINT[16];
    int COST[16];
    int seq1[16] = '{100,73,50,35,29,35,50,73,100,127,150,165,171,165,150,127};

    psk_symbol_detector dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_sof      (in_sof),
        .in_sample   (in_sample),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_phase   (out_phase),
        .out_i       (out_i),
        .out_q       (out_q),
        .out_erasure (out_erasure),
        .err_sof     (err_sof),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (err_sof) err_cnt <= err_cnt + 1;
    always @(posedge clk) if (rst_n && out_valid && out_ready) res_cnt <= res_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_phase(input int i, input int q);
        int ai, aq, mj, mn;
        ai = (i < 0) ? -i : i;
        aq = (q < 0) ? -q : q;
        mj = (ai >= aq) ? ai : aq;
        mn = (ai >= aq) ? aq : ai;
        if (5 * mn < 2 * mj) begin
            if (ai >= aq) return (i < 0) ? 4 : 0;
            return (q < 0) ? 6 : 2;
        end
        if (i >= 0) return (q >= 0) ? 1 : 7;
        return (q >= 0) ? 3 : 5;
    endfunction

    // Reference correlation of one completed symbol; advances the DC estimate.
    task automatic model_sym(input int s[16], output int mi, output int mq,
                             output int mph, output int mer);
        int sum, c, ai, aq;
        mi = 0; mq = 0; sum = 0;
        for (int n = 0; n < 16; n++) begin
            c   = s[n] - model_dc;
            mi += c * SINT[n];
            mq += c * COST[n];
            sum += s[n];
        end
        ai  = (mi < 0) ? -mi : mi;
        aq  = (mq < 0) ? -mq : mq;
        mph = model_phase(mi, mq);
        mer = (ai + aq < 4096) ? 1 : 0;
`ifdef PSK_DC_TRACK_EN
        model_dc = sum / 16;
`endif
    endtask

    task automatic send_symbol(input int s[16], input int gap_max, input int cnt);
        for (int n = 0; n < cnt; n++) begin
            repeat ($urandom_range(gap_max, 0)) begin
                @(negedge clk);
                in_valid  = 1'b0;
                in_sof    = 1'($urandom);
                in_sample = 8'($urandom);
            end
            @(negedge clk);
            in_valid  = 1'b1;
            in_sof    = (n == 0);
            in_sample = 8'(s[n]);
            @(posedge clk);
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n = 0;
        while (!out_valid && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic gen_sym(output int s[16]);
        int amp, v;
        case ($urandom_range(2, 0))
            0:       amp = 2;
            1:       amp = 30;
            default: amp = 90;
        endcase
        for (int n = 0; n < 16; n++) begin
            v = 100 + int'($urandom_range(2 * amp, 0)) - amp;
            s[n] = (v < 0) ? 0 : (v > 255) ? 255 : v;
        end
    endtask

    task automatic chk_result(input string tag, input int mi, input int mq,
                              input int mph, input int mer);
        chk({tag, "_i"}, out_i, mi);
        chk({tag, "_q"}, out_q, mq);
        chk({tag, "_phase"}, out_phase, mph);
        chk({tag, "_erasure"}, out_erasure, mer);
    endtask

    initial begin
        int s[16], a[16], b[16], mir[16];
        int mi, mq, mph, mer, mi2, mq2, mph2, mer2;
        int e0, r0;

        for (int n = 0; n < 16; n++) begin
            SINT[n] = $rtoi($floor(64.0 * $sin(2.0 * 3.14159265358979 * n / 16.0) + 0.5));
            COST[n] = $rtoi($floor(64.0 * $cos(2.0 * 3.14159265358979 * n / 16.0) + 0.5));
            mir[n]  = 200 - seq1[n];
        end

        rst_n = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_sample = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_i", out_i, 0);
        chk("rst_q", out_q, 0);
        chk("rst_phase", out_phase, 0);
        chk("rst_erasure", out_erasure, 0);
        chk("rst_err_sof", err_sof, 0);
        chk("rst_overrun", overrun, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reference symbol, no gaps, latency check.
        send_symbol(seq1, 0, 16);
        go_idle();
        chk("lat_edge1", out_valid, 0);
        @(negedge clk);
        chk("lat_edge2", out_valid, 0);
        @(negedge clk);
        chk("lat_edge3", out_valid, 1);
        chk_result("seq1", -36020, 0, 4, 0);
        model_sym(seq1, mi, mq, mph, mer);

        // Flat symbol: zero energy.
        for (int n = 0; n < 16; n++) s[n] = 100;
        send_symbol(s, 2, 16);
        go_idle();
        wait_valid("flat_wait", 20);
        chk("flat_i", out_i, 0);
        chk("flat_q", out_q, 0);
        chk("flat_erasure", out_erasure, 1);
        model_sym(s, mi, mq, mph, mer);

        // Mid-symbol sof aborts, second symbol decodes.
        @(negedge clk);
        e0 = err_cnt; r0 = res_cnt;
        send_symbol(seq1, 1, 7);
        send_symbol(mir, 1, 16);
        go_idle();
        wait_valid("abort_wait", 20);
        chk_result("abort", 36020, 0, 0, 0);
        model_sym(mir, mi, mq, mph, mer);
        @(negedge clk);
        chk("abort_err_pulses", err_cnt - e0, 1);
        chk("abort_results", res_cnt - r0, 1);
        chk("abort_valid_drop", out_valid, 0);

        // Back-to-back symbols into a stalled sink.
        out_ready = 1'b0;
        e0 = err_cnt; r0 = res_cnt;
        gen_sym(a); gen_sym(b);
        model_sym(a, mi, mq, mph, mer);
        model_sym(b, mi2, mq2, mph2, mer2);
        send_symbol(a, 0, 16);
        send_symbol(b, 0, 16);
        go_idle();
        repeat (4) @(negedge clk);
        chk("stall_valid", out_valid, 1);
        chk_result("stall_held", mi, mq, mph, mer);
        chk("stall_overrun", overrun, 1);
        chk("stall_no_err_sof", err_cnt - e0, 0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_consumed", out_valid, 0);
        chk("stall_results", res_cnt - r0, 1);
        chk("stall_overrun_sticky", overrun, 1);

        // Pure tones at every 22.5 degree step.
        for (int m = 0; m < 16; m++) begin
            for (int n = 0; n < 16; n++) s[n] = 100 + SINT[(n + m) % 16];
            model_sym(s, mi, mq, mph, mer);
            send_symbol(s, 1, 16);
            go_idle();
            wait_valid("tone_wait", 20);
            chk_result("tone", mi, mq, mph, mer);
            if (m % 2 == 0) chk("tone_sector", out_phase, m / 2);
            @(negedge clk);
        end

        // Random symbols with random gaps.
        for (int k = 0; k < 10; k++) begin
            gen_sym(s);
            model_sym(s, mi, mq, mph, mer);
            send_symbol(s, 3, 16);
            go_idle();
            wait_valid("rand_wait", 20);
            chk_result("rand", mi, mq, mph, mer);
            @(negedge clk);
        end

        // Asynchronous reset in the middle of a symbol.
        send_symbol(seq1, 0, 9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_i", out_i, 0);
        chk("arst_q", out_q, 0);
        chk("arst_phase", out_phase, 0);
        chk("arst_overrun", overrun, 0);
        go_idle();
        rst_n = 1'b1;
        model_dc = 100;
        @(negedge clk);
        send_symbol(seq1, 1, 16);
        go_idle();
        wait_valid("arst_sym_wait", 20);
        chk_result("arst_sym", -36020, 0, 4, 0);
        model_sym(seq1, mi, mq, mph, mer);
        @(negedge clk);

`ifdef PSK_DC_TRACK_EN
        for (int n = 0; n < 16; n++) s[n] = 110;
        send_symbol(s, 0, 16);
        go_idle();
        wait_valid("dc1_wait", 20);
        model_sym(s, mi, mq, mph, mer);
        @(negedge clk);
        for (int n = 0; n < 16; n++) s[n] = seq1[n] + 10;
        send_symbol(s, 1, 16);
        go_idle();
        wait_valid("dc2_wait", 20);
        chk("dc2_i", out_i, -36020);
        chk("dc2_q", out_q, 0);
        chk("dc2_phase", out_phase, 4);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
